// File: rtl/mem_port_responder_pkg.sv
// Shared widths, FSM state encoding and latched-request payload for the
// mem_port_responder scratchpad front end.
package mem_port_responder_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } resp_state_t;

    // Request captured at grant time; it stays fixed for the whole access.
    typedef struct packed {
        logic [IDX_W-1:0] grant;
        logic             write;
        logic             bad_op;
        logic             oob;
    } op_t;

    // Region is half-open: [lo, hi).
    function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/mem_port_responder_if.sv
// Initiator-side mem_handle channel bundle for all NUM_PORTS ports.
interface mem_port_responder_if;
    import mem_port_responder_pkg::*;

    logic [NUM_PORTS-1:0]             avail;
    logic [NUM_PORTS-1:0]             r_en;
    logic [NUM_PORTS-1:0]             w_en;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] ptr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_store;
    logic [NUM_PORTS-1:0]             done;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_load;
    logic                             err;

    modport master (
        output avail, r_en, w_en, ptr, data_store,
        input  done, data_load, err
    );

    modport slave (
        input  avail, r_en, w_en, ptr, data_store,
        output done, data_load, err
    );

endinterface

// File: rtl/mem_port_responder_rr_arbiter.sv
// Combinational round-robin pick: first requesting port after last_grant wins.
module mem_port_responder_rr_arbiter
    import mem_port_responder_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_PORTS);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = found;
    end

endmodule

// File: rtl/mem_port_responder.sv
// Responder end of mem_handle: round-robin serves NUM_PORTS initiators onto one
// single-port synchronous SRAM with per-port region checking.
module mem_port_responder
    import mem_port_responder_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    mem_port_responder_if.slave              mem,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] region_start,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] region_end,
    output logic                             sram_en,
    output logic                             sram_we,
    output logic [ADDR_W-1:0]                sram_addr,
    output logic [DATA_W-1:0]                sram_wdata,
    input  logic [DATA_W-1:0]                sram_rdata
);

    localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    resp_state_t                      state_q, state_d;
    op_t                              op_q, op_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 last_q, last_d;
    logic [NUM_PORTS-1:0]             done_q, done_d;
    logic                             err_q, err_d;
    logic                             en_d, we_d;
    logic [ADDR_W-1:0]                addr_d;
    logic [DATA_W-1:0]                wdata_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_load_q, data_load_d;

    logic [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0]             arb_grant;
    logic [IDX_W-1:0]                 arb_idx;
    logic                             arb_found;
    logic                             pick_w, pick_r, pick_in;

    assign req = mem.avail & (mem.r_en | mem.w_en);

    mem_port_responder_rr_arbiter u_arb (
        .req        (req),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .found      (arb_found)
    );

    // Attributes of the winning request; a read+write request is a write.
    assign pick_w  = |(arb_grant & mem.w_en);
    assign pick_r  = |(arb_grant & mem.r_en);
    assign pick_in = in_region(mem.ptr[arb_idx], region_start[arb_idx], region_end[arb_idx]);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        done_d      = '0;
        err_d       = 1'b0;
        en_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = sram_addr;
        wdata_d     = sram_wdata;
        data_load_d = data_load_q;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d     = ISSUE;
                    op_d.grant  = arb_idx;
                    op_d.write  = pick_w;
                    op_d.bad_op = pick_w & pick_r;
                    op_d.oob    = ~pick_in;
                    en_d        = pick_in;
                    we_d        = pick_in & pick_w;
                    addr_d      = mem.ptr[arb_idx];
                    wdata_d     = mem.data_store[arb_idx];
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (op_q.oob || op_q.write) begin
                    // Writes and rejected accesses need no SRAM turnaround.
                    state_d             = RESP;
                    done_d[op_q.grant]  = 1'b1;
                    err_d               = op_q.oob | op_q.bad_op;
                    if (op_q.oob && !op_q.write) begin
                        data_load_d[op_q.grant] = '0;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                    state_d                 = RESP;
                    done_d[op_q.grant]      = 1'b1;
                    data_load_d[op_q.grant] = sram_rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // Always return through IDLE so the served initiator can drop avail.
                state_d = IDLE;
                last_d  = op_q.grant;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            last_q      <= IDX_W'(NUM_PORTS - 1);
            done_q      <= '0;
            err_q       <= 1'b0;
            sram_en     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            data_load_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sram_en     <= en_d;
            sram_we     <= we_d;
            sram_addr   <= addr_d;
            sram_wdata  <= wdata_d;
            data_load_q <= data_load_d;
        end
    end

    assign mem.done      = done_q;
    assign mem.err       = err_q;
    assign mem.data_load = data_load_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized initiators.
module tb_mem_port_responder;
    import mem_port_responder_pkg::*;

    localparam int unsigned RL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_responder_if bus ();

    logic [NUM_PORTS-1:0][ADDR_W-1:0] rs, re;
    logic              sram_en, sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata, sram_rdata;

    mem_port_responder #(.READ_LAT(RL)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus),
        .region_start (rs),
        .region_end   (re),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // SRAM: strobe sampled mid-cycle, acted on at the next rising edge.
    logic [DATA_W-1:0] smem [0:65535];
    logic [DATA_W-1:0] rpipe [RL];
    assign sram_rdata = rpipe[RL-1];

    initial begin : sram_model
        logic              s_en, s_we;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] s_wd;
        for (int i = 0; i < 65536; i++) smem[i] = '0;
        for (int k = 0; k < int'(RL); k++) rpipe[k] <= '0;
        forever begin
            @(negedge clk);
            s_en = sram_en; s_we = sram_we; s_addr = sram_addr; s_wd = sram_wdata;
            @(posedge clk);
            for (int k = int'(RL) - 1; k > 0; k--) rpipe[k] <= rpipe[k-1];
            if (s_en && s_we) smem[s_addr] = s_wd;
            rpipe[0] <= (s_en && !s_we) ? smem[s_addr] : '0;
        end
    end

    // Transaction-level reference: one access at a time, timing from the latency rules.
    logic [DATA_W-1:0] mm [int];
    logic [DATA_W-1:0] m_dl [NUM_PORTS];
    logic [NUM_PORTS-1:0] saw_done;
    int cyc = 0;

    initial begin : checker_model
        bit m_active, m_w, m_bad, m_inr, retired, picked;
        int m_g, m_t, m_done, m_last, q;
        logic [ADDR_W-1:0] m_ptr;
        logic [DATA_W-1:0] m_data;
        logic [NUM_PORTS-1:0] exp_done;
        logic exp_err, exp_en, exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        m_active = 0; m_last = NUM_PORTS - 1; m_g = 0; m_t = 0; m_done = 0;
        m_w = 0; m_bad = 0; m_inr = 0; m_ptr = '0; m_data = '0;
        saw_done = '0;
        for (int p = 0; p < NUM_PORTS; p++) m_dl[p] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            exp_done = '0; exp_err = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
            if (rst) begin
                m_active = 0;
                m_last   = NUM_PORTS - 1;
                for (int p = 0; p < NUM_PORTS; p++) m_dl[p] = '0;
            end else begin
                retired = 0;
                if (m_active) begin
                    if (cyc == m_t + 1 && m_inr) begin
                        exp_en = 1; exp_we = m_w; exp_addr = m_ptr; exp_wdata = m_data;
                    end
                    if (cyc == m_done) begin
                        exp_done[m_g] = 1'b1;
                        exp_err = !m_inr || m_bad;
                        if (!m_w) m_dl[m_g] = !m_inr ? '0 : (mm.exists(int'(m_ptr)) ? mm[int'(m_ptr)] : '0);
                        else if (m_inr) mm[int'(m_ptr)] = m_data;
                        m_active = 0; m_last = m_g; retired = 1;
                    end
                end
                if (!m_active && !retired) begin
                    picked = 0;
                    for (int i = 1; i <= NUM_PORTS; i++) begin
                        q = (m_last + i) % NUM_PORTS;
                        if (!picked && bus.avail[q] && (bus.r_en[q] || bus.w_en[q])) begin
                            picked = 1; m_g = q; m_t = cyc;
                            m_w    = bus.w_en[q];
                            m_bad  = bus.w_en[q] && bus.r_en[q];
                            m_ptr  = bus.ptr[q];
                            m_data = bus.data_store[q];
                            m_inr  = (bus.ptr[q] >= rs[q]) && (bus.ptr[q] < re[q]);
                            m_done = cyc + ((m_w || !m_inr) ? 2 : 2 + int'(RL));
                        end
                    end
                    m_active = picked;
                end
            end
            check("done", 64'(bus.done), 64'(exp_done));
            check("err", 64'(bus.err), 64'(exp_err));
            check("sram_en", 64'(sram_en), 64'(exp_en));
            if (exp_en) begin
                check("sram_we", 64'(sram_we), 64'(exp_we));
                check("sram_addr", 64'(sram_addr), 64'(exp_addr));
                check("sram_wdata", 64'(sram_wdata), 64'(exp_wdata));
            end
            for (int p = 0; p < NUM_PORTS; p++)
                check($sformatf("data_load[%0d]", p), 64'(bus.data_load[p]), 64'(m_dl[p]));
            saw_done = saw_done | bus.done;
        end
    end

    task automatic raise(input int p, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.avail[p] = 1'b1; bus.r_en[p] = r; bus.w_en[p] = w;
        bus.ptr[p] = a; bus.data_store[p] = d;
    endtask

    task automatic drop(input int p);
        bus.avail[p] = 1'b0; bus.r_en[p] = 1'b0; bus.w_en[p] = 1'b0;
    endtask

    int a_lat;
    logic [NUM_PORTS-1:0] a_dv;
    logic a_err, a_en, a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;

    // One access on port p; reports cycles from request to done and what the SRAM saw.
    task automatic access(input int p, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        raise(p, r, w, a, d);
        a_lat = -1; a_dv = '0; a_err = 0; a_en = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sram_en) begin a_en = 1; a_we = sram_we; a_addr = sram_addr; a_wdata = sram_wdata; end
            if (bus.done[p]) begin a_lat = k; a_dv = bus.done; a_err = bus.err; break; end
        end
        @(posedge clk); #1;
        drop(p);
    endtask

    logic [NUM_PORTS-1:0] br, bw;
    logic [ADDR_W-1:0] bp [NUM_PORTS];
    logic [DATA_W-1:0] bd [NUM_PORTS];
    int ord [4];

    // Raise the masked ports together and record the order in which done arrives.
    task automatic burst(input logic [NUM_PORTS-1:0] mask, input bit late0, input int nexp);
        int n = 0;
        int got;
        bit raised = 0;
        for (int i = 0; i < 4; i++) ord[i] = -1;
        @(posedge clk); #1;
        for (int p = 0; p < NUM_PORTS; p++) if (mask[p]) raise(p, br[p], bw[p], bp[p], bd[p]);
        for (int k = 0; k < 80 && n < nexp; k++) begin
            @(negedge clk);
            got = -1;
            for (int p = 0; p < NUM_PORTS; p++) if (bus.done[p]) got = p;
            @(posedge clk); #1;
            if (got >= 0) begin ord[n] = got; n++; drop(got); end
            if (late0 && n == 1 && !raised) begin raised = 1; raise(0, br[0], bw[0], bp[0], bd[0]); end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin : main
        int kind, lo, hi;
        logic r, w;
        logic [NUM_PORTS-1:0] nullreq;
        bus.avail = '0; bus.r_en = '0; bus.w_en = '0; bus.ptr = '0; bus.data_store = '0;
        rs[0] = 16'h0000; re[0] = 16'h0040;
        rs[1] = 16'h0010; re[1] = 16'h0060;
        rs[2] = 16'h0100; re[2] = 16'h0200;
        rs[3] = 16'h0030; re[3] = 16'h0080;

        repeat (2) @(negedge clk);
        check("rst_done", 64'(bus.done), 64'h0);
        check("rst_sram_en", 64'(sram_en), 64'h0);
        check("rst_sram_addr", 64'(sram_addr), 64'h0);
        check("rst_data_load", 64'(bus.data_load), 64'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Write then read back on port 0.
        access(0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
        check("t1_latency", 64'(a_lat), 64'd2);
        check("t1_done_onehot", 64'(a_dv), 64'b0001);
        check("t1_we", 64'(a_we), 64'h1);
        check("t1_addr", 64'(a_addr), 64'h10);
        check("t1_wdata", 64'(a_wdata), 64'hDEADBEEF);
        access(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        check("t2_latency", 64'(a_lat), 64'(2 + RL));
        check("t2_data", 64'(bus.data_load[0]), 64'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1 check("t2_data_held", 64'(bus.data_load[0]), 64'hDEADBEEF);

        // All four write at once straight out of reset, then a rotated burst.
        pulse_reset();
        br = '0; bw = '1;
        bp[0] = 16'h01;  bp[1] = 16'h21;  bp[2] = 16'h101; bp[3] = 16'h31;
        bd[0] = 32'hA0;  bd[1] = 32'hA1;  bd[2] = 32'hA2;  bd[3] = 32'hA3;
        burst(4'b1111, 1'b0, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_order%0d", i), 64'(ord[i]), 64'(i));
        bd[0] = 32'hB0;  bd[1] = 32'hB1;  bd[2] = 32'hB2;  bd[3] = 32'hB3;
        burst(4'b1110, 1'b1, 4);
        check("t3_rot0", 64'(ord[0]), 64'd1);
        check("t3_rot1", 64'(ord[1]), 64'd2);
        check("t3_rot2", 64'(ord[2]), 64'd3);
        check("t3_rot3", 64'(ord[3]), 64'd0);

        // Region end is exclusive: reading at region_end is rejected.
        access(2, 1'b1, 1'b0, 16'h0101, 32'h0);
        check("t4_pre_data", 64'(bus.data_load[2]), 64'hB2);
        access(2, 1'b1, 1'b0, 16'h0200, 32'h0);
        check("t4_latency", 64'(a_lat), 64'd2);
        check("t4_no_sram", 64'(a_en), 64'h0);
        check("t4_done", 64'(a_dv), 64'b0100);
        check("t4_err", 64'(a_err), 64'h1);
        check("t4_data_zero", 64'(bus.data_load[2]), 64'h0);

        // r_en and w_en together behave as a flagged write.
        access(1, 1'b1, 1'b1, 16'h0020, 32'h5);
        check("t5_latency", 64'(a_lat), 64'd2);
        check("t5_we", 64'(a_en & a_we), 64'h1);
        check("t5_err", 64'(a_err), 64'h1);
        access(1, 1'b1, 1'b0, 16'h0020, 32'h0);
        check("t5_readback", 64'(bus.data_load[1]), 64'h5);
        check("t5_read_err", 64'(a_err), 64'h0);

        // Reset during a read's WAIT cycle abandons it.
        access(3, 1'b1, 1'b0, 16'h0031, 32'h0);
        check("t6_pre_data", 64'(bus.data_load[3]), 64'hB3);
        @(posedge clk); #1; raise(3, 1'b1, 1'b0, 16'h0031, 32'h0);
        @(posedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("t6_rst_done", 64'(bus.done), 64'h0);
        check("t6_rst_en", 64'(sram_en), 64'h0);
        check("t6_rst_data", 64'(bus.data_load[3]), 64'h0);
        drop(3);
        repeat (2) begin @(negedge clk); check("t6_no_done", 64'(bus.done), 64'h0); end
        @(posedge clk); #1; rst = 1'b0;
        bp[0] = 16'h02; bp[3] = 16'h32; bd[0] = 32'hC0; bd[3] = 32'hC3;
        burst(4'b1001, 1'b0, 2);
        check("t6_first", 64'(ord[0]), 64'd0);
        check("t6_second", 64'(ord[1]), 64'd3);

        // Randomized initiators; the model checks every cycle.
        saw_done = '0; nullreq = '0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.avail[p]) begin
                    if (saw_done[p] || nullreq[p]) begin
                        drop(p); saw_done[p] = 1'b0; nullreq[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    kind = int'($urandom_range(0, 9));
                    r = (kind >= 1 && kind <= 5); w = (kind == 1 || kind >= 6);
                    nullreq[p] = (kind == 0);
                    lo = (int'(rs[p]) >= 2) ? int'(rs[p]) - 2 : 0;
                    hi = int'(re[p]) + 1;
                    raise(p, r, w, ADDR_W'($urandom_range(hi, lo)), $urandom);
                end
            end
        end
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < NUM_PORTS; p++)
                if (bus.avail[p] && (saw_done[p] || nullreq[p])) begin
                    drop(p); saw_done[p] = 1'b0; nullreq[p] = 1'b0;
                end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
